// File: rtl/mrv1_thread_sched.sv
// Per-thread instruction buffer and round-robin issue scheduler feeding mrv1_idecode.
// Optional build macro MRV1_THREAD_SCHED_PERF_EN adds per-thread issue and stall counters.
module mrv1_thread_sched #(
  parameter int NUM_THREADS_P = 8,
  parameter int PC_WIDTH_P    = 32,
  localparam int TID_WIDTH_LP = $clog2(NUM_THREADS_P)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_THREADS_P-1:0]   thread_en_i,
  input  logic                       fetch_vld_i,
  input  logic [31:0]                fetch_insn_i,
  input  logic [PC_WIDTH_P-1:0]      fetch_pc_i,
  input  logic [TID_WIDTH_LP-1:0]    fetch_tid_i,
  output logic [NUM_THREADS_P-1:0]   fetch_rdy_o,
  output logic                       insn_vld_o,
  output logic [31:0]                insn_o,
  output logic [PC_WIDTH_P-1:0]      insn_pc_o,
  output logic [TID_WIDTH_LP-1:0]    insn_tid_o,
  input  logic                       insn_rdy_i,
  input  logic                       dec_b_is_branch_i,
  input  logic                       dec_b_is_jump_i,
  input  logic                       resolve_vld_i,
  input  logic [TID_WIDTH_LP-1:0]    resolve_tid_i,
  input  logic                       flush_i,
  input  logic [TID_WIDTH_LP-1:0]    flush_tid_i,
  output logic [2*NUM_THREADS_P-1:0] dbg_state_o,
  output logic [TID_WIDTH_LP-1:0]    dbg_rr_ptr_o
`ifdef MRV1_THREAD_SCHED_PERF_EN
  ,
  output logic [NUM_THREADS_P*32-1:0] perf_issue_cnt_o,
  output logic [31:0]                 perf_stall_cnt_o
`endif
);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_FULL    = 2'd1;
  localparam logic [1:0] ST_WAIT_BR = 2'd2;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // ready never depends on valid, and the producer holds data stable while valid waits.
  logic [1:0]              state_q [NUM_THREADS_P];
  logic [1:0]              state_d [NUM_THREADS_P];
  logic [31:0]             insn_q  [NUM_THREADS_P];
  logic [PC_WIDTH_P-1:0]   pc_q    [NUM_THREADS_P];
  logic [TID_WIDTH_LP-1:0] rr_ptr_q;
  logic [TID_WIDTH_LP-1:0] rr_next;
  logic [TID_WIDTH_LP-1:0] grant;
  logic                    grant_vld;
  logic [NUM_THREADS_P-1:0] eligible;
  logic [NUM_THREADS_P-1:0] flush_hit;
  logic [NUM_THREADS_P-1:0] fetch_wr;
  logic [NUM_THREADS_P-1:0] full_vec;
  logic                    fetch_acc;
  logic                    issue;
  logic                    issue_ctrl;

  always_comb begin
    fetch_rdy_o = '0;
    eligible    = '0;
    flush_hit   = '0;
    full_vec    = '0;
    dbg_state_o = '0;
    for (int t = 0; t < NUM_THREADS_P; t++) begin
      flush_hit[t]       = flush_i && (flush_tid_i == TID_WIDTH_LP'(t));
      full_vec[t]        = (state_q[t] == ST_FULL);
      fetch_rdy_o[t]     = thread_en_i[t] && (state_q[t] == ST_EMPTY);
      eligible[t]        = full_vec[t] && thread_en_i[t] && !flush_hit[t];
      dbg_state_o[2*t +: 2] = state_q[t];
    end
  end

  assign fetch_acc    = fetch_vld_i && fetch_rdy_o[fetch_tid_i];
  assign dbg_rr_ptr_o = rr_ptr_q;

  // Round-robin search starting at rr_ptr_q, which holds the highest priority.
  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_vld = 1'b0;
    for (int i = 0; i < NUM_THREADS_P; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NUM_THREADS_P) j = j - NUM_THREADS_P;
      if (!grant_vld && eligible[j]) begin
        grant_vld = 1'b1;
        grant     = TID_WIDTH_LP'(j);
      end
    end
  end

  assign insn_vld_o = grant_vld;
  assign insn_o     = grant_vld ? insn_q[grant] : '0;
  assign insn_pc_o  = grant_vld ? pc_q[grant]   : '0;
  assign insn_tid_o = grant_vld ? grant         : '0;

  assign issue      = grant_vld && insn_rdy_i;
  assign issue_ctrl = dec_b_is_branch_i || dec_b_is_jump_i;
  assign rr_next    = (grant == TID_WIDTH_LP'(NUM_THREADS_P - 1)) ? '0 : grant + TID_WIDTH_LP'(1);

  // Flush takes priority over fetch, issue and resolve of the same thread.
  always_comb begin
    for (int t = 0; t < NUM_THREADS_P; t++) begin
      state_d[t]  = state_q[t];
      fetch_wr[t] = 1'b0;
      if (flush_hit[t]) begin
        state_d[t] = ST_EMPTY;
      end else begin
        case (state_q[t])
          ST_EMPTY: begin
            if (fetch_acc && (fetch_tid_i == TID_WIDTH_LP'(t))) begin
              state_d[t]  = ST_FULL;
              fetch_wr[t] = 1'b1;
            end
          end
          ST_FULL: begin
            if (issue && (grant == TID_WIDTH_LP'(t)))
              state_d[t] = issue_ctrl ? ST_WAIT_BR : ST_EMPTY;
          end
          ST_WAIT_BR: begin
            if (resolve_vld_i && (resolve_tid_i == TID_WIDTH_LP'(t)))
              state_d[t] = ST_EMPTY;
          end
          default: state_d[t] = ST_EMPTY;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      for (int t = 0; t < NUM_THREADS_P; t++) begin
        state_q[t] <= ST_EMPTY;
        insn_q[t]  <= '0;
        pc_q[t]    <= '0;
      end
    end else begin
      if (issue) rr_ptr_q <= rr_next;
      for (int t = 0; t < NUM_THREADS_P; t++) begin
        state_q[t] <= state_d[t];
        if (fetch_wr[t]) begin
          insn_q[t] <= fetch_insn_i;
          pc_q[t]   <= fetch_pc_i;
        end
      end
    end
  end

`ifdef MRV1_THREAD_SCHED_PERF_EN
  logic [31:0] issue_cnt_q [NUM_THREADS_P];
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      for (int t = 0; t < NUM_THREADS_P; t++) issue_cnt_q[t] <= '0;
    end else begin
      if ((|full_vec) && !insn_rdy_i && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      for (int t = 0; t < NUM_THREADS_P; t++)
        if (issue && (grant == TID_WIDTH_LP'(t))) issue_cnt_q[t] <= issue_cnt_q[t] + 32'd1;
    end
  end

  always_comb begin
    perf_issue_cnt_o = '0;
    for (int t = 0; t < NUM_THREADS_P; t++) perf_issue_cnt_o[32*t +: 32] = issue_cnt_q[t];
  end
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

`ifndef SYNTHESIS
  // Fetches aimed at a busy or disabled thread are dropped; the fetch unit should never do that.
  a_fetch_to_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
    fetch_vld_i |-> fetch_rdy_o[fetch_tid_i]);
`endif

endmodule

// File: tb/tb_mrv1_thread_sched.sv
// Directed bench for mrv1_thread_sched: issue scoreboard plus per-cycle output checks.
module tb_mrv1_thread_sched;

  localparam int NT = 8;
  localparam int EW = 3 + 32 + 32;

  logic          clk_i;
  logic          rst_ni;
  logic [NT-1:0] thread_en_i;
  logic          fetch_vld_i;
  logic [31:0]   fetch_insn_i;
  logic [31:0]   fetch_pc_i;
  logic [2:0]    fetch_tid_i;
  logic [NT-1:0] fetch_rdy_o;
  logic          insn_vld_o;
  logic [31:0]   insn_o;
  logic [31:0]   insn_pc_o;
  logic [2:0]    insn_tid_o;
  logic          insn_rdy_i;
  logic          dec_b_is_branch_i;
  logic          dec_b_is_jump_i;
  logic          resolve_vld_i;
  logic [2:0]    resolve_tid_i;
  logic          flush_i;
  logic [2:0]    flush_tid_i;
  logic [2*NT-1:0] dbg_state_o;
  logic [2:0]    dbg_rr_ptr_o;
`ifdef MRV1_THREAD_SCHED_PERF_EN
  logic [NT*32-1:0] perf_issue_cnt_o;
  logic [31:0]      perf_stall_cnt_o;
`endif

  mrv1_thread_sched #(.NUM_THREADS_P(NT), .PC_WIDTH_P(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .thread_en_i(thread_en_i),
    .fetch_vld_i(fetch_vld_i), .fetch_insn_i(fetch_insn_i), .fetch_pc_i(fetch_pc_i),
    .fetch_tid_i(fetch_tid_i), .fetch_rdy_o(fetch_rdy_o),
    .insn_vld_o(insn_vld_o), .insn_o(insn_o), .insn_pc_o(insn_pc_o), .insn_tid_o(insn_tid_o),
    .insn_rdy_i(insn_rdy_i), .dec_b_is_branch_i(dec_b_is_branch_i), .dec_b_is_jump_i(dec_b_is_jump_i),
    .resolve_vld_i(resolve_vld_i), .resolve_tid_i(resolve_tid_i),
    .flush_i(flush_i), .flush_tid_i(flush_tid_i),
    .dbg_state_o(dbg_state_o), .dbg_rr_ptr_o(dbg_rr_ptr_o)
`ifdef MRV1_THREAD_SCHED_PERF_EN
    , .perf_issue_cnt_o(perf_issue_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
  );

  // clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [31:0]   ins_r [NT];
  logic [31:0]   pc_r  [NT];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] st(input int t);
    return dbg_state_o[2*t +: 2];
  endfunction

  function automatic logic [EW-1:0] exp_of(input int t);
    return {3'(t), pc_r[t], ins_r[t]};
  endfunction

  // driver tasks: inputs change 2ns after the rising edge, outputs sampled on the falling edge
  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic fetch(input int t);
    ins_r[t]     = $urandom;
    pc_r[t]      = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
    fetch_vld_i  = 1'b1;
    fetch_tid_i  = 3'(t);
    fetch_insn_i = ins_r[t];
    fetch_pc_i   = pc_r[t];
    step();
    fetch_vld_i  = 1'b0;
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
  endtask

  // scoreboard: every issue handshake must match the oldest expected entry
  always @(negedge clk_i) begin
    if (rst_ni && insn_vld_o && insn_rdy_i) begin
      check("issue_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("issue_data", {insn_tid_o, insn_pc_o, insn_o}, exp_q.pop_front());
    end
  end

  initial begin
    int prev;
    int t;
    rst_ni = 1'b1; thread_en_i = 8'hFF;
    fetch_vld_i = 1'b0; fetch_insn_i = '0; fetch_pc_i = '0; fetch_tid_i = '0;
    insn_rdy_i = 1'b0; dec_b_is_branch_i = 1'b0; dec_b_is_jump_i = 1'b0;
    resolve_vld_i = 1'b0; resolve_tid_i = '0; flush_i = 1'b0; flush_tid_i = '0;
    #1 rst_ni = 1'b0;
    #1;
    check("rst_vld", insn_vld_o, 0);
    check("rst_data", {insn_o, insn_pc_o, insn_tid_o}, 0);
    check("rst_fetch_rdy", fetch_rdy_o, 8'hFF);
    check("rst_rr", dbg_rr_ptr_o, 0);
    step(); step();
    rst_ni = 1'b1;

    // single fetch to tid3, visible the next cycle
    ins_r[3] = 32'h0000_0013; pc_r[3] = 32'h100;
    fetch_vld_i = 1'b1; fetch_tid_i = 3'd3; fetch_insn_i = ins_r[3]; fetch_pc_i = pc_r[3];
    step();
    fetch_vld_i = 1'b0;
    sample();
    check("t1_vld", insn_vld_o, 1);
    check("t1_tid", insn_tid_o, 3);
    check("t1_insn", insn_o, 32'h13);
    check("t1_pc", insn_pc_o, 32'h100);
    check("t1_rdy3_busy", fetch_rdy_o[3], 0);
    step();
    insn_rdy_i = 1'b1;
    exp_q.push_back(exp_of(3));
    step();
    insn_rdy_i = 1'b0;
    sample();
    check("t1_rdy3_free", fetch_rdy_o[3], 1);
    check("t1_rr", dbg_rr_ptr_o, 4);

    // round-robin order from rr_ptr 0
    apply_reset();
    fetch(0); fetch(2); fetch(5);
    insn_rdy_i = 1'b1;
    exp_q.push_back(exp_of(0)); exp_q.push_back(exp_of(2)); exp_q.push_back(exp_of(5));
    step(); step(); step();
    insn_rdy_i = 1'b0;
    sample();
    check("t2_rr", dbg_rr_ptr_o, 6);
    check("t2_idle", insn_vld_o, 0);

    // branch parks tid1 until its resolve
    fetch(1);
    insn_rdy_i = 1'b1; dec_b_is_branch_i = 1'b1;
    exp_q.push_back(exp_of(1));
    step();
    insn_rdy_i = 1'b0; dec_b_is_branch_i = 1'b0;
    sample();
    check("t3_parked_rdy", fetch_rdy_o[1], 0);
    check("t3_parked_state", st(1), 2);
    resolve_vld_i = 1'b1; resolve_tid_i = 3'd2;
    step();
    resolve_vld_i = 1'b0;
    sample();
    check("t3_other_resolve", fetch_rdy_o[1], 0);
    resolve_vld_i = 1'b1; resolve_tid_i = 3'd1;
    step();
    resolve_vld_i = 1'b0;
    sample();
    check("t3_resolved", fetch_rdy_o[1], 1);
    check("t3_rr", dbg_rr_ptr_o, 2);

    // stall: tid0 held stable (wrap from rr 2), then 0 and 1 issue
    fetch(0); fetch(1);
    for (int k = 0; k < 4; k++) begin
      sample();
      check("t4_hold_vld", insn_vld_o, 1);
      check("t4_hold_tid", {insn_tid_o, insn_pc_o}, {3'd0, pc_r[0]});
      check("t4_hold_rr", dbg_rr_ptr_o, 2);
      step();
    end
    insn_rdy_i = 1'b1;
    exp_q.push_back(exp_of(0)); exp_q.push_back(exp_of(1));
    step(); step();
    insn_rdy_i = 1'b0;
    sample();
    check("t4_rr", dbg_rr_ptr_o, 2);

    // flush of the sole granted thread blocks issue
    fetch(4);
    flush_i = 1'b1; flush_tid_i = 3'd4; insn_rdy_i = 1'b1;
    sample();
    check("t5_flush_vld", insn_vld_o, 0);
    step();
    flush_i = 1'b0; insn_rdy_i = 1'b0;
    sample();
    check("t5_state", st(4), 0);
    check("t5_rdy", fetch_rdy_o[4], 1);
    check("t5_rr", dbg_rr_ptr_o, 2);

    // disabled thread keeps its buffer
    fetch(5);
    thread_en_i = 8'hDF;
    sample();
    check("en_off_vld", insn_vld_o, 0);
    check("en_off_rdy", fetch_rdy_o, 8'hDF);
    step(); step();
    thread_en_i = 8'hFF;
    sample();
    check("en_on", {insn_vld_o, insn_tid_o, insn_pc_o, insn_o}, {1'b1, 3'd5, pc_r[5], ins_r[5]});
    insn_rdy_i = 1'b1;
    exp_q.push_back(exp_of(5));
    step();
    insn_rdy_i = 1'b0;

    // flush and fetch to the same thread: fetch dropped
    fetch_vld_i = 1'b1; fetch_tid_i = 3'd7; fetch_insn_i = 32'hdead_beef; fetch_pc_i = 32'h700;
    flush_i = 1'b1; flush_tid_i = 3'd7;
    step();
    fetch_vld_i = 1'b0; flush_i = 1'b0;
    sample();
    check("ff_vld", insn_vld_o, 0);
    check("ff_state", st(7), 0);

    // jump parks tid2; flush and resolve together leave it EMPTY
    fetch(2);
    insn_rdy_i = 1'b1; dec_b_is_jump_i = 1'b1;
    exp_q.push_back(exp_of(2));
    step();
    insn_rdy_i = 1'b0; dec_b_is_jump_i = 1'b0;
    sample();
    check("t6_jump_state", st(2), 2);
    flush_i = 1'b1; flush_tid_i = 3'd2; resolve_vld_i = 1'b1; resolve_tid_i = 3'd2;
    step();
    flush_i = 1'b0; resolve_vld_i = 1'b0;
    sample();
    check("t6_flush_res", {st(2), fetch_rdy_o[2]}, {2'd0, 1'b1});

    // back-to-back fetches with decode always ready: one issue per cycle
    insn_rdy_i = 1'b1;
    prev = 2;
    for (int k = 0; k < 12; k++) begin
      t = $urandom_range(0, NT - 1);
      if (t == prev) t = (t + 1) % NT;
      prev = t;
      fetch(t);
      exp_q.push_back(exp_of(t));
    end
    step();
    insn_rdy_i = 1'b0;
    sample();
    check("tp_drained", exp_q.size(), 0);

    // reset mid-stream with buffered and parked threads
    fetch(6);
    insn_rdy_i = 1'b1; dec_b_is_branch_i = 1'b1;
    exp_q.push_back(exp_of(6));
    step();
    insn_rdy_i = 1'b0; dec_b_is_branch_i = 1'b0;
    fetch(0); fetch(3);
    thread_en_i = 8'h5A;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_vld", insn_vld_o, 0);
    check("mid_rst_data", {insn_o, insn_pc_o, insn_tid_o}, 0);
    check("mid_rst_rdy", fetch_rdy_o, 8'h5A);
    check("mid_rst_state", dbg_state_o, 0);
    check("mid_rst_rr", dbg_rr_ptr_o, 0);
    step();
    rst_ni = 1'b1;
    thread_en_i = 8'hFF;
    sample();
    check("post_rst_vld", insn_vld_o, 0);
    check("post_rst_rdy", fetch_rdy_o, 8'hFF);
    check("final_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
